// File: rtl/runctl_pkg.sv
// Shared encodings for the CPU run controller: FSM state codes and load-target codes.
package runctl_pkg;

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    typedef enum logic [1:0] {
        S_LOAD = ST_LOAD,
        S_RUN  = ST_RUN,
        S_DONE = ST_DONE
    } state_t;

    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

endpackage

// File: rtl/runctl_ld_if.sv
// Image-load handshake between a loader (master) and the run controller (slave).
interface runctl_ld_if #(
    parameter int ADDR_W = 10,
    parameter int DATA_W = 32
);
    logic              ld_valid;
    logic              ld_ready;
    logic              ld_target;
    logic [ADDR_W-1:0] ld_addr;
    logic [DATA_W-1:0] ld_data;
    logic              ld_last;

    modport master (
        output ld_valid, ld_target, ld_addr, ld_data, ld_last,
        input  ld_ready
    );

    modport slave (
        input  ld_valid, ld_target, ld_addr, ld_data, ld_last,
        output ld_ready
    );
endinterface

// File: rtl/runctl_halt_det.sv
// PC-repeat halt detector: flags the cycle in which the PC has matched its previous
// value for HALT_REPEAT consecutive run cycles (the `j .` end-of-program idiom).
module runctl_halt_det #(
    parameter int DATA_W      = 32,
    parameter int HALT_REPEAT = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              run,
    input  logic [DATA_W-1:0] pc,
    output logic              halt
);
    localparam int CNT_W = $clog2(HALT_REPEAT + 1);

    logic [DATA_W-1:0] prev_pc;
    logic              prev_valid;
    logic [CNT_W-1:0]  rep_cnt;
    logic              same_pc;

    assign same_pc = run && prev_valid && (pc == prev_pc);
    assign halt    = same_pc && (rep_cnt == CNT_W'(HALT_REPEAT - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_pc    <= '0;
            prev_valid <= 1'b0;
            rep_cnt    <= '0;
        end else if (!run) begin
            prev_valid <= 1'b0;
            rep_cnt    <= '0;
        end else begin
            prev_pc    <= pc;
            prev_valid <= 1'b1;
            if (!same_pc)
                rep_cnt <= '0;
            else if (!halt)
                rep_cnt <= rep_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/cpu_run_controller.sv
// Loads IMEM/DMEM images with the CPU held in reset, then runs it for a bounded budget.
// Define RUNCTL_HALT_DETECT_EN to also end the run on a repeating PC (timeout = 0).
module cpu_run_controller
    import runctl_pkg::*;
#(
    parameter int DATA_W      = 32,
    parameter int ADDR_W      = 10,
    parameter int CYCLE_W     = 16,
    parameter int MAX_CYCLES  = 100,
    parameter int HALT_REPEAT = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    runctl_ld_if.slave         ld,
    output logic               imem_we,
    output logic               dmem_we,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [DATA_W-1:0]  mem_wdata,
    output logic               cpu_rst_n,
    input  logic [DATA_W-1:0]  cpu_pc,
    output logic               busy,
    output logic               done,
    output logic               timeout,
    output logic [CYCLE_W-1:0] cycles
);
    state_t state, state_nx;
    logic   in_run;
    logic   ld_fire;
    logic   budget_hit;
    logic   halt;

    assign in_run      = (state == S_RUN);
    assign ld.ld_ready = !in_run;
    assign ld_fire     = ld.ld_valid && ld.ld_ready;
    assign budget_hit  = in_run && (cycles == CYCLE_W'(MAX_CYCLES - 1));
    assign busy        = (state != S_DONE);
    assign done        = (state == S_DONE);

`ifdef RUNCTL_HALT_DETECT_EN
    runctl_halt_det #(
        .DATA_W      (DATA_W),
        .HALT_REPEAT (HALT_REPEAT)
    ) u_halt_det (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (in_run),
        .pc    (cpu_pc),
        .halt  (halt)
    );
`else
    logic unused_pc;
    assign unused_pc = ^cpu_pc;
    assign halt      = 1'b0;
`endif

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state <= S_LOAD;
        else
            state <= state_nx;
    end

    // NOTE: next state gets its default first, so no path through the case can infer a latch.
    always_comb begin
        state_nx = state;
        unique case (state)
            S_LOAD:  if (ld_fire && ld.ld_last) state_nx = S_RUN;
            S_RUN:   if (halt || budget_hit)    state_nx = S_DONE;
            S_DONE:  if (ld_fire)               state_nx = ld.ld_last ? S_RUN : S_LOAD;
            default: state_nx = S_LOAD;
        endcase
    end

    // NOTE: every datapath register has a reset value; there is no storage array here to exempt.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            imem_we   <= 1'b0;
            dmem_we   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            cpu_rst_n <= 1'b0;
            timeout   <= 1'b0;
            cycles    <= '0;
        end else begin
            imem_we   <= ld_fire && (ld.ld_target == TGT_IMEM);
            dmem_we   <= ld_fire && (ld.ld_target == TGT_DMEM);
            cpu_rst_n <= (state_nx == S_RUN);
            if (ld_fire) begin
                mem_addr  <= ld.ld_addr;
                mem_wdata <= ld.ld_data;
            end
            if (in_run) begin
                if (cycles != '1)
                    cycles <= cycles + 1'b1;
                // Halt has priority over the budget when both land in the same cycle.
                if (state_nx == S_DONE)
                    timeout <= !halt;
            end else if (ld_fire) begin
                cycles  <= '0;
                timeout <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_cpu_run_controller.sv
// Scoreboard bench for cpu_run_controller: load, budget run, mid-run reset, reload from DONE.
module tb_cpu_run_controller;
    import runctl_pkg::*;

    localparam int DATA_W      = 32;
    localparam int ADDR_W      = 10;
    localparam int CYCLE_W     = 16;
    localparam int MAX_CYCLES  = 100;
    localparam int HALT_REPEAT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    runctl_ld_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) ld ();

    logic               imem_we, dmem_we, cpu_rst_n, busy, done, timeout;
    logic [ADDR_W-1:0]  mem_addr;
    logic [DATA_W-1:0]  mem_wdata, cpu_pc;
    logic [CYCLE_W-1:0] cycles;

    cpu_run_controller #(
        .DATA_W      (DATA_W),
        .ADDR_W      (ADDR_W),
        .CYCLE_W     (CYCLE_W),
        .MAX_CYCLES  (MAX_CYCLES),
        .HALT_REPEAT (HALT_REPEAT)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld        (ld.slave),
        .imem_we   (imem_we),
        .dmem_we   (dmem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .cpu_rst_n (cpu_rst_n),
        .cpu_pc    (cpu_pc),
        .busy      (busy),
        .done      (done),
        .timeout   (timeout),
        .cycles    (cycles)
    );

    typedef struct {
        logic              tgt;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_t;

    wr_t exp_q[$];
    int  n_checks = 0;
    int  n_fail   = 0;
    int  run_cnt  = 0;
    bit  pc_stick = 1'b0;
    int  exp_to;
    int  exp_cyc;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%0h exp=0x%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // CPU stand-in: counts cycles it was out of reset; PC advances by 4 or sticks at 0x10.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            run_cnt <= 0;
        else if (!cpu_rst_n)
            run_cnt <= 0;
        else
            run_cnt <= run_cnt + 1;
    end
    assign cpu_pc = (pc_stick && run_cnt >= 20) ? 32'h10 : 32'(run_cnt * 4);

    // Each accepted word must appear as exactly one strobe on the following cycle.
    always @(negedge clk) begin
        wr_t e;
        if (rst_n) begin
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("imem_we", imem_we, e.tgt == TGT_IMEM);
                check("dmem_we", dmem_we, e.tgt == TGT_DMEM);
                check("mem_addr", mem_addr, e.addr);
                check("mem_wdata", mem_wdata, e.data);
            end else begin
                check("idle_we", {imem_we, dmem_we}, 0);
            end
        end
    end

    task automatic send(input logic tgt, input logic [ADDR_W-1:0] addr,
                        input logic [DATA_W-1:0] data, input logic last);
        wr_t w;
        @(negedge clk);
        check("ld_ready", ld.ld_ready, 1);
        ld.ld_valid  = 1'b1;
        ld.ld_target = tgt;
        ld.ld_addr   = addr;
        ld.ld_data   = data;
        ld.ld_last   = last;
        @(posedge clk);
        w.tgt  = tgt;
        w.addr = addr;
        w.data = data;
        exp_q.push_back(w);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            ld.ld_valid = 1'b0;
            ld.ld_last  = 1'b0;
        end
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while (done !== 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", done, 1);
    endtask

    initial begin
        int n;
        ld.ld_valid  = 1'b0;
        ld.ld_target = TGT_IMEM;
        ld.ld_addr   = '0;
        ld.ld_data   = '0;
        ld.ld_last   = 1'b0;
        repeat (2) @(negedge clk);

        check("rst_ready", ld.ld_ready, 1);
        check("rst_we", {imem_we, dmem_we}, 0);
        check("rst_addr", mem_addr, 0);
        check("rst_wdata", mem_wdata, 0);
        check("rst_cpu_rst_n", cpu_rst_n, 0);
        check("rst_busy", busy, 1);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_cycles", cycles, 0);
        rst_n = 1'b1;

        // Three IMEM words back to back; the last one starts the run.
        send(TGT_IMEM, 10'd0, 32'h0000_0013, 1'b0);
        send(TGT_IMEM, 10'd1, 32'h0010_0093, 1'b0);
        send(TGT_IMEM, 10'd2, 32'h0000_006F, 1'b1);
        idle(1);
        check("run_cpu_rst_n", cpu_rst_n, 1);
        check("run_busy", busy, 1);
        check("run_cycles0", cycles, 0);
        check("run_done", done, 0);

        // Load requests while running must be refused and never written.
        repeat (5) begin
            @(negedge clk);
            ld.ld_valid  = 1'b1;
            ld.ld_target = TGT_DMEM;
            ld.ld_addr   = 10'd7;
            check("run_ready", ld.ld_ready, 0);
        end
        idle(1);

        wait_done(200);
        check("to_timeout", timeout, 1);
        check("to_cycles", cycles, MAX_CYCLES);
        check("to_run_len", run_cnt, MAX_CYCLES);
        check("to_cpu_rst_n", cpu_rst_n, 0);
        check("to_busy", busy, 0);
        check("to_ready", ld.ld_ready, 1);
        idle(3);
        check("done_hold", done, 1);
        check("cycles_frozen", cycles, MAX_CYCLES);

        // From DONE: DMEM/IMEM interleave, including the top word address.
        send(TGT_DMEM, 10'd5, 32'hDEAD_BEEF, 1'b0);
        idle(1);
        check("reload_done", done, 0);
        check("reload_timeout", timeout, 0);
        check("reload_cycles", cycles, 0);
        check("reload_busy", busy, 1);
        check("reload_cpu_rst_n", cpu_rst_n, 0);
        send(TGT_IMEM, 10'd3, 32'h0000_0033, 1'b0);
        send(TGT_DMEM, 10'd6, 32'h0000_0001, 1'b0);
        send(TGT_IMEM, 10'h3FF, 32'hCAFE_F00D, 1'b1);
        idle(1);
        check("run2_cpu_rst_n", cpu_rst_n, 1);

        // Asynchronous reset in the middle of a run.
        n = 0;
        while (run_cnt != 50 && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("run50_cycles", cycles, 50);
        rst_n = 1'b0;
        #1;
        check("arst_cpu_rst_n", cpu_rst_n, 0);
        check("arst_ready", ld.ld_ready, 1);
        check("arst_cycles", cycles, 0);
        check("arst_busy", busy, 1);
        check("arst_done", done, 0);
        @(negedge clk);
        rst_n = 1'b1;

`ifdef RUNCTL_HALT_DETECT_EN
        pc_stick = 1'b1;
        exp_to   = 0;
        exp_cyc  = 20 + HALT_REPEAT + 1;
`else
        exp_to   = 1;
        exp_cyc  = MAX_CYCLES;
`endif
        send(TGT_IMEM, 10'd0, 32'h0000_006F, 1'b1);
        idle(1);
        wait_done(200);
        check("run3_timeout", timeout, exp_to);
        check("run3_cycles", cycles, exp_cyc);
        pc_stick = 1'b0;

        // A single last word in DONE goes straight back to RUN.
        send(TGT_DMEM, 10'd9, 32'h1234_5678, 1'b1);
        idle(1);
        check("d2r_done", done, 0);
        check("d2r_timeout", timeout, 0);
        check("d2r_cycles", cycles, 0);
        check("d2r_cpu_rst_n", cpu_rst_n, 1);
        wait_done(200);
        check("run4_cycles", cycles, MAX_CYCLES);
        idle(2);
        check("queue_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
